// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, controller state encoding and the
// control-strobe bundle. The IR, ALU, top level and controller all import this.
// No ports.
package cpu_pkg;

  localparam int OPW = 3;

  typedef enum logic [2:0] {
    HLT  = 3'd0,
    SKZ  = 3'd1,
    ADD  = 3'd2,
    ANDD = 3'd3,
    XORR = 3'd4,
    LDA  = 3'd5,
    STO  = 3'd6,
    JMP  = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    HALTED = 4'd8
  } state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_pc;
    logic load_ir;
    logic load_acc;
    logic rd;
    logic wr;
    logic datactl_ena;
    logic halt;
  } strobe_t;

  // Ring successor for S0..S7; HALTED never advances.
  function automatic state_t next_seq(state_t s);
    case (s)
      S7:      return S0;
      HALTED:  return HALTED;
      default: return state_t'(s + 4'd1);
    endcase
  endfunction

endpackage

// File: rtl/machine_ctl_if.sv
// Bundle between the instruction-sequencing controller and the datapath.
// master: controller side (consumes fetch/opcode/zero, drives strobes).
// slave:  datapath side (drives fetch/opcode/zero, consumes strobes).
// Optional sync_err signal exists only when MACHINE_SYNC_CHECK_EN is defined.
interface machine_ctl_if #(parameter int OPW = 3);

  logic           fetch;
  logic [OPW-1:0] opcode;
  logic           zero;
  logic           inc_pc;
  logic           load_pc;
  logic           load_ir;
  logic           load_acc;
  logic           rd;
  logic           wr;
  logic           datactl_ena;
  logic           halt;
`ifdef MACHINE_SYNC_CHECK_EN
  logic           sync_err;
`endif

  modport master (
    input  fetch, opcode, zero,
    output inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt
`ifdef MACHINE_SYNC_CHECK_EN
    , output sync_err
`endif
  );

  modport slave (
    output fetch, opcode, zero,
    input  inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt
`ifdef MACHINE_SYNC_CHECK_EN
    , input sync_err
`endif
  );

endinterface

// File: rtl/machine_decode.sv
// Combinational strobe decode of (state, opcode, zero), gated by ena.
// Ports: state, opcode, zero, ena in; strobes out (cpu_pkg::strobe_t).
// Opcode is not looked at in S0-S2, so it may change freely there.
module machine_decode
  import cpu_pkg::*;
(
  input  state_t  state,
  input  opcode_t opcode,
  input  logic    zero,
  input  logic    ena,
  output strobe_t strobes
);

  always_comb begin
    strobes = '0;
    if (ena) begin
      case (state)
        S0, S1: begin
          strobes.rd      = 1'b1;
          strobes.load_ir = 1'b1;
          strobes.inc_pc  = 1'b1;
        end
        S3: strobes.halt = (opcode == HLT);
        S4: begin
          case (opcode)
            ADD, ANDD, XORR, LDA: strobes.rd          = 1'b1;
            STO:                  strobes.datactl_ena = 1'b1;
            JMP:                  strobes.load_pc     = 1'b1;
            SKZ:                  strobes.inc_pc      = zero;
            default: ;
          endcase
        end
        S5: begin
          case (opcode)
            ADD, ANDD, XORR, LDA: begin
              strobes.rd       = 1'b1;
              strobes.load_acc = 1'b1;
            end
            STO: begin
              strobes.datactl_ena = 1'b1;
              strobes.wr          = 1'b1;
            end
            default: ;
          endcase
        end
        S6: begin
          case (opcode)
            STO:     strobes.datactl_ena = 1'b1;
            // second increment completes the skip of one 2-byte instruction
            SKZ:     strobes.inc_pc      = zero;
            default: ;
          endcase
        end
        HALTED:  strobes.halt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/machine_ctl.sv
// Instruction-sequencing controller. Holds the enable flag, the 8-step state
// register and the HLT lock; strobes come from machine_decode.
// Ports: clk (tied to the phase generator's clk1), rst (async, active high),
// bus (machine_ctl_if.master: fetch/opcode/zero in, PC/IR/ACC/mem strobes out).
// Parameters: OPW (opcode width, 3 only), HALT_STICKY (1: HLT locks until reset).
// Optional: MACHINE_SYNC_CHECK_EN adds sticky sync_err and holds S0 while fetch=0.
module machine_ctl
  import cpu_pkg::*;
#(
  parameter int OPW         = 3,
  parameter bit HALT_STICKY = 1'b1
) (
  input logic           clk,
  input logic           rst,
  machine_ctl_if.master bus
);

  state_t         state_q, state_d;
  logic           ena_q;
  logic [OPW-1:0] opcode_raw;
  opcode_t        opcode;
  strobe_t        dec, strobes;
  logic           sync_hold;

  assign opcode_raw = bus.opcode;
  assign opcode     = opcode_t'(opcode_raw);

  machine_decode u_decode (
    .state   (state_q),
    .opcode  (opcode),
    .zero    (bus.zero),
    .ena     (ena_q),
    .strobes (dec)
  );

`ifdef MACHINE_SYNC_CHECK_EN
  logic sync_err_q;

  // Reaching S0 without fetch means the sequence slipped against the phase
  // generator: stall there with strobes off until fetch comes back.
  assign sync_hold = ena_q && (state_q == S0) && !bus.fetch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_err_q <= 1'b0;
    else if (sync_hold) sync_err_q <= 1'b1;
  end

  assign bus.sync_err = sync_err_q;
`else
  assign sync_hold = 1'b0;
`endif

  // Enable latches on the first sampled fetch and stays until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ena_q <= 1'b0;
    else if (bus.fetch) ena_q <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S0;
    else state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ena_q && !sync_hold) begin
      if (state_q == S3 && opcode == HLT && HALT_STICKY) state_d = HALTED;
      else state_d = next_seq(state_q);
    end
  end

  assign strobes = sync_hold ? '0 : dec;

  assign bus.inc_pc      = strobes.inc_pc;
  assign bus.load_pc     = strobes.load_pc;
  assign bus.load_ir     = strobes.load_ir;
  assign bus.load_acc    = strobes.load_acc;
  assign bus.rd          = strobes.rd;
  assign bus.wr          = strobes.wr;
  assign bus.datactl_ena = strobes.datactl_ena;
  assign bus.halt        = strobes.halt;

endmodule

// File: tb/tb_machine_ctl.sv
module tb_machine_ctl;
  import cpu_pkg::*;

  // strobe vector order: {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt}
  localparam logic [7:0] IDL  = 8'h00;
  localparam logic [7:0] FCH  = 8'hA8;
  localparam logic [7:0] RD   = 8'h08;
  localparam logic [7:0] RDA  = 8'h18;
  localparam logic [7:0] DC   = 8'h02;
  localparam logic [7:0] WRD  = 8'h06;
  localparam logic [7:0] LPC  = 8'h40;
  localparam logic [7:0] INC  = 8'h80;
  localparam logic [7:0] HLTB = 8'h01;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic exp_serr = 1'b0;

  machine_ctl_if #(.OPW(3)) bus ();

  machine_ctl #(.OPW(3), .HALT_STICKY(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MACHINE_SYNC_CHECK_EN
  wire serr = bus.sync_err;
`else
  wire serr = 1'b0;
`endif

  wire [8:0] act = {serr, bus.inc_pc, bus.load_pc, bus.load_ir, bus.load_acc,
                    bus.rd, bus.wr, bus.datactl_ena, bus.halt};

  logic [8:0] sb[$];
  string      names[$];
  int checks = 0;
  int errors = 0;

  // Monitor: compares once per cycle (just after negedge) and right after any
  // reset assertion, against whatever the stimulus queued.
  initial begin
    logic [8:0] e;
    string nm;
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (sb.size() > 0) begin
        e  = sb.pop_front();
        nm = names.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %b want %b at %0t", nm, act, e, $time);
        end
      end
    end
  end

  task automatic check_now(input logic [8:0] e, input string nm);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s (direct): got %b want %b at %0t", nm, act, e, $time);
    end
  endtask

  task automatic expect_now(input logic [7:0] e, input string nm);
    sb.push_back({exp_serr, e});
    names.push_back(nm);
  endtask

  task automatic step(input logic f, input logic [2:0] op, input logic z,
                      input logic [7:0] e, input string nm);
    bus.fetch  = f;
    bus.opcode = op;
    bus.zero   = z;
    expect_now(e, nm);
    @(posedge clk);
    #1;
  endtask

  // One full instruction; S0/S1 carry a garbage opcode to show it is ignored.
  task automatic pass(input logic [2:0] op, input logic z, input logic [7:0] e4,
                      input logic [7:0] e5, input logic [7:0] e6, input string nm);
    step(1'b1, ~op, z, FCH, {nm, "/S0"});
    step(1'b1, ~op, z, FCH, {nm, "/S1"});
    step(1'b1, op,  z, IDL, {nm, "/S2"});
    step(1'b1, op,  z, IDL, {nm, "/S3"});
    step(1'b1, op,  z, e4,  {nm, "/S4"});
    step(1'b1, op,  z, e5,  {nm, "/S5"});
    step(1'b1, op,  z, e6,  {nm, "/S6"});
    step(1'b1, op,  z, IDL, {nm, "/S7"});
  endtask

  initial begin
    bus.fetch  = 1'b0;
    bus.opcode = 3'd0;
    bus.zero   = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) step(1'b0, 3'd2, 1'b0, IDL, "in_reset");
    check_now(9'h000, "reset_state");
    rst = 1'b0;
    repeat (10) step(1'b0, 3'd2, 1'b1, IDL, "wait_fetch");
    step(1'b1, 3'd2, 1'b0, IDL, "ena_edge");

    pass(ADD,  1'b0, RD,  RDA, IDL, "add");
    pass(STO,  1'b0, DC,  WRD, DC,  "sto");
    pass(SKZ,  1'b1, INC, IDL, INC, "skz_z1");
    pass(SKZ,  1'b0, IDL, IDL, IDL, "skz_z0");
    pass(JMP,  1'b1, LPC, IDL, IDL, "jmp");
    pass(LDA,  1'b1, RD,  RDA, IDL, "lda");
    pass(XORR, 1'b0, RD,  RDA, IDL, "xorr");

`ifdef MACHINE_SYNC_CHECK_EN
    step(1'b0, 3'd2, 1'b0, IDL, "sync_drop");
    exp_serr = 1'b1;
    step(1'b0, 3'd2, 1'b0, IDL, "sync_hold");
    pass(ADD, 1'b0, RD, RDA, IDL, "sync_resume");
`endif

    step(1'b1, ~HLT, 1'b0, FCH, "hlt/S0");
    step(1'b1, ~HLT, 1'b0, FCH, "hlt/S1");
    step(1'b1, HLT,  1'b0, IDL, "hlt/S2");
    step(1'b1, HLT,  1'b0, HLTB, "hlt/S3");
    for (int i = 0; i < 22; i++) step(1'b1, 3'(i), 1'(i), HLTB, "halted");
    check_now({exp_serr, HLTB}, "halt_wait_expired");

    rst = 1'b1;
    exp_serr = 1'b0;
    step(1'b0, 3'd2, 1'b0, IDL, "rst_pulse");
    rst = 1'b0;
    repeat (3) step(1'b0, 3'd2, 1'b0, IDL, "post_rst");
    step(1'b1, 3'd2, 1'b0, IDL, "ena2");

    step(1'b1, ~ADD, 1'b0, FCH, "add2/S0");
    step(1'b1, ~ADD, 1'b0, FCH, "add2/S1");
    step(1'b1, ADD,  1'b0, IDL, "add2/S2");
    step(1'b1, ADD,  1'b0, IDL, "add2/S3");
    step(1'b1, ADD,  1'b0, RD,  "add2/S4");
    expect_now(RDA, "add2/S5");
    #6;
    expect_now(IDL, "async_rst");
    rst = 1'b1;
    #2;
    @(posedge clk);
    #1;
    step(1'b0, 3'd2, 1'b0, IDL, "held_rst");
    rst = 1'b0;
    repeat (2) step(1'b0, 3'd2, 1'b0, IDL, "after_async");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL unchecked expectations left: %0d", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
